// File: rtl/uart_cmd_wrapper.sv
// UART front end: pairs received 8N1 bytes into a 16-bit command
// and serialises a single response byte back to the remote.
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        trmt,
  input  logic [7:0]  resp,
  output logic        tx_done
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_XMIT
  } tx_state_t;

  logic          r_rx_meta;
  logic          r_rx_sync;
  logic          r_rx_prev;
  rx_state_t     r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]    r_rx_bits;
  logic [7:0]    r_rx_shift;
  logic          r_rx_byte;

  logic          r_asm_low;
  logic [15:0]   r_cmd;
  logic          r_cmd_rdy;

  tx_state_t     r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bits;
  logic [9:0]    r_tx_shift;
  logic          r_tx_done;

  logic w_fall;
  logic w_start_ok;
  logic w_frm_err;

  assign w_fall = r_rx_prev & ~r_rx_sync;

  assign w_start_ok = (r_rx_state == RX_START) &&
                      (r_rx_cnt == HALF_LAST) &&
                      !r_rx_sync;

  assign w_frm_err = (r_rx_state == RX_STOP) &&
                     (r_rx_cnt == BAUD_LAST) &&
                     !r_rx_sync;

  assign TX      = r_tx_shift[0];
  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;
  assign tx_done = r_tx_done;

  // Presetting to 1 keeps reset release from looking like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bits  <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= 1'b0;
    end else begin
      r_rx_byte <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          if (w_fall) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_bits  <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == BAUD_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bits  <= r_rx_bits + 4'd1;
            if (r_rx_bits == 4'd7) r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == BAUD_LAST) begin
            r_rx_cnt <= '0;
            if (r_rx_sync) begin
              r_rx_byte  <= 1'b1;
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state <= RX_WAIT;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        RX_WAIT: begin
          if (r_rx_sync) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // A new start bit drops the flag so it never covers a half-written cmd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm_low <= 1'b0;
      r_cmd     <= '0;
      r_cmd_rdy <= 1'b0;
    end else begin
      if (r_rx_byte) begin
        if (!r_asm_low) begin
          r_cmd[15:8] <= r_rx_shift;
          r_asm_low   <= 1'b1;
        end else begin
          r_cmd[7:0]  <= r_rx_shift;
          r_asm_low   <= 1'b0;
        end
      end else if (w_frm_err) begin
        r_asm_low <= 1'b0;
      end
      if (r_rx_byte && r_asm_low) begin
        r_cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy || w_start_ok) begin
        r_cmd_rdy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bits  <= '0;
      r_tx_shift <= '1;
      r_tx_done  <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (trmt) begin
            r_tx_shift <= {1'b1, resp, 1'b0};
            r_tx_cnt   <= '0;
            r_tx_bits  <= '0;
            r_tx_done  <= 1'b0;
            r_tx_state <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (r_tx_cnt == BAUD_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_shift <= {1'b1, r_tx_shift[9:1]};
            if (r_tx_bits == 4'd9) begin
              r_tx_done  <= 1'b1;
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_bits <= r_tx_bits + 4'd1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
- Serial front end of KnightsTour. It sits between the RX/TX pins (driven by RemoteComm) and the command processor.
- Receives 8N1 UART bytes, pairs them into one 16-bit command (high byte first), and presents it with a ready flag held until cleared by the consumer.
- Also serialises the 8-bit response byte (e.g. positive ack 8'hA5) back to the remote.

Parameters:
BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud); must be >= 8.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
RX  input  1  serial in from remote, asynchronous, idles high
TX  output  1  serial out to remote, idles high
cmd  output  16  assembled command, {first byte, second byte}
cmd_rdy  output  1  full command available
clr_cmd_rdy  input  1  consumer acknowledge, clears cmd_rdy
trmt  input  1  one-cycle pulse: transmit resp
resp  input  8  response byte, captured on trmt
tx_done  output  1  response byte fully sent

Behaviour:
- Reset values: TX=1, cmd=16'h0000, cmd_rdy=0, tx_done=0. Internal state: receiver IDLE, assembler HIGH, transmitter IDLE, all counters 0.
- Reset deasserted mid-frame: any partial byte or partial command is discarded; the next falling edge starts a fresh HIGH byte.
- RX synchronisation: RX passes through two flops, preset to 1 on reset; all logic uses the synchronised value. Start of a byte is a 1->0 transition seen in IDLE.
- Receiver FSM, states IDLE -> START -> DATA -> STOP -> IDLE, with a baud counter and a 4-bit bit counter.
  - START: wait BAUD_DIV/2 clocks, then resample. If the line is 1, treat it as a glitch and return to IDLE with no byte.
  - DATA: sample every BAUD_DIV clocks, 8 bits, LSB first, shifted into an 8-bit register.
  - STOP: sample after BAUD_DIV clocks.
    - Stop=1: byte valid, pulse an internal rx_byte for 1 clk.
    - Stop=0: framing error. Drop the byte, reset the assembler to HIGH, wait for the line to return high, then go to IDLE.
- Assembler, states HIGH / LOW:
  - HIGH + rx_byte: store cmd[15:8] and go to LOW.
  - LOW + rx_byte: store cmd[7:0], set cmd_rdy the next clk, go to HIGH.
  - cmd holds its value until the next high byte overwrites cmd[15:8].
- cmd_rdy:
  - Cleared by clr_cmd_rdy.
  - Also cleared when the start bit of a following byte is accepted, so a stale flag never covers a partially-updated cmd.
  - If set and clear occur in the same cycle, set wins.
- Latency: cmd_rdy rises exactly 1 clk after the stop-bit sample of the second byte.
- Transmitter FSM, states IDLE -> XMIT -> IDLE, using a 10-bit shift register {1, resp, 0} and its own baud counter.
  - trmt in IDLE: load the frame, clear tx_done, drive the start bit the next clk.
  - Each bit is held BAUD_DIV clocks; the whole frame takes 10*BAUD_DIV clocks.
  - After the stop bit: return to IDLE, set tx_done (held until the next trmt), TX=1.
  - trmt while in XMIT is ignored; the frame in flight is unchanged.
- RX and TX are fully independent; simultaneous receive and transmit are supported (full duplex).

Test Plan:
- BAUD_DIV=16. After reset, send bytes 8'h4B then 8'hF1 on RX.
  - Required: cmd_rdy rises 1 clk after the second stop sample, cmd=16'h4BF1.
  - Pulse clr_cmd_rdy: cmd_rdy falls the next clk, cmd still 16'h4BF1.
- Send 8'h57 then 8'hF2 without clearing.
  - Required: cmd_rdy drops when the 8'h57 start bit is accepted, rises again with cmd=16'h57F2.
- Send 8'h12 with stop bit forced 0, then 8'hAB, 8'hCD.
  - Required: no cmd_rdy from the bad byte; cmd=16'hABCD after the two good bytes.
- Drive a 3-clk low glitch on RX.
  - Required: no byte is accepted, assembler stays HIGH; the next 2-byte command assembles correctly.
- Pulse trmt with resp=8'hA5.
  - Required: TX shows 0,1,0,1,0,0,1,0,1,1, each held 16 clk; tx_done rises after 160 clk.
  - Pulse trmt again at clk 40 of the frame: frame is unchanged.
- Assert rst_n=0 mid-way through the first byte of a command, then release and send 8'h01, 8'h02.
  - Required: all outputs at reset values during reset; afterwards cmd=16'h0102, cmd_rdy=1.
